sbox_share_compress: RTL and testbench
======================================

Name: sbox_share_compress

Overview:
- Downstream neighbour of the 2-share TI tower-field inversion stage.
- Consumes the 4 output shares of the inversion and re-masks them with fresh randomness.
- Compresses them to 2 shares, applies the AES output linear map and the 0x63 constant, and registers the result as the 2-share S-box output.
- Also carries the byte-valid/last tags across the inversion's fixed pipeline latency and counts output bytes of a 16-byte state.

Parameters:
- INV_LAT, 2, register stages inside the upstream inversion (in_valid to shares valid at this block's inputs).
- NBYTES, 16, bytes per state; wrap value of the output byte index.

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- in_valid  input  1  byte presented at the inversion input this cycle.
- in_last  input  1  tag: byte is the last of a state; qualified by in_valid.
- sh0, sh1, sh2, sh3  input  8 each  inversion output shares; valid INV_LAT cycles after matching in_valid.
- r_comp  input  8  fresh random byte for compression, sampled every cycle.
- out0, out1  output  8 each  2-share S-box output.
- out_valid  output  1  out0/out1 hold a valid byte.
- out_last  output  1  tag of the output byte.
- out_idx  output  4  index 0..NBYTES-1 of the current output byte.

Behaviour:
- Reset (async, RST=1): all registers clear immediately.
  - out0=out1=0x00, out_valid=0, out_last=0, out_idx=0.
  - Any in-flight bytes are dropped.
  - First output after release only follows an in_valid sampled after release.
- Tag pipeline:
  - {in_valid, in_last} pass through INV_LAT delay registers, then through stages C and O below.
  - in_last is ignored when in_valid=0.
- Stage C (compress register), every cycle, no enable:
  - q0<=sh0^r_comp, q1<=sh1, q2<=sh2^r_comp, q3<=sh3.
  - Each share is registered separately before any cross-share XOR (glitch isolation).
- Stage O (output register), every cycle:
  - out0<=L(q0^q1)^0x63, out1<=L(q2^q3).
  - L is the fixed GF(2) 8x8 matrix: inverse tower-basis isomorphism composed with the AES affine matrix.
  - Invariant: out0^out1 = L(sh0^sh1^sh2^sh3)^0x63, i.e. S(x) for the unmasked byte x.
- Latency: in_valid at cycle t -> out_valid at t+INV_LAT+2 (t+4 at default). Fully pipelined, one byte per cycle, no back-pressure.
- Shares are updated every cycle regardless of valid. Only out_valid qualifies them. Downstream ignores shares when out_valid=0.
- out_idx:
  - Increments after each cycle with out_valid=1.
  - Wraps NBYTES-1 -> 0.
  - If out_valid and out_last, the next value is 0, overriding the increment (resync).
  - Holds when out_valid=0.
- out_last is forced to 0 whenever out_valid=0.
- Gaps in in_valid propagate unchanged; back-to-back bytes are never merged.

Decomposition:
- Shared package aes_ti_pkg holds:
  - the L matrix as a constant array of 8 row masks;
  - the constant 0x63;
  - INV_LAT default;
  - NBYTES default.
- One sub-module: gf8_linmap (combinational 8-bit matrix-vector product over GF(2), matrix passed as parameter), instantiated twice in stage O.

Test Plan:
- Zero and constant shares:
  - All shares=0x00, r_comp=0x00, in_valid pulse at t -> out_valid at t+4, out0^out1=0x63.
  - Repeat with r_comp=0xA5 -> same XOR, out1=L(0xA5).
- Exhaustive unmasking:
  - For each byte x, set sh0..sh2 random and sh3=invtower(x) XOR the others.
  - Expect out0^out1 = AES S-box of corresponding input (e.g. input 0x53 -> 0xED) for all 256 values.
- Streaming and wrap:
  - 20 consecutive valid bytes, in_last=0 -> out_idx sequence 0..15,0..3; out_valid high 20 cycles.
- Last resync:
  - Bytes 0..4 with in_last on byte 4, then a 3-cycle gap, then 2 bytes.
  - Expect out_last only on the 5th output and out_idx=0,1 on the trailing bytes.
- Gaps:
  - in_valid pattern 1,0,1,1,0,1 -> out_valid identical pattern delayed 4 cycles.
- Reset mid-flight:
  - Assert RST asynchronously while 3 bytes are in flight.
  - Expect outputs zero and out_valid=0 same cycle, no spurious out_valid after release, out_idx=0.

Source files
------------

// File: rtl/aes_ti_pkg.sv
// Constants shared by the masked AES S-box datapath. The tower field is
// GF(((2^2)^2)^2) built as w^2+w+1, z^2+z+w, y^2+y+w*z.
package aes_ti_pkg;

    typedef logic [7:0][7:0] lmat_t;

    localparam int INV_LAT_DEF = 2;
    localparam int NBYTES_DEF  = 16;

    localparam logic [7:0] SBOX_CONST = 8'h63;

    // Tower basis element i written in the AES polynomial basis (x^8+x^4+x^3+x+1):
    // 1, w, z, wz, y, wy, zy, wzy with w=0xBD, z=0xE0, y=0x42.
    localparam lmat_t TOWER_BASIS = {8'h92, 8'hE5, 8'hF5, 8'h42,
                                     8'hED, 8'hE0, 8'hBD, 8'h01};

    // Linear part of the AES affine map: bit i = b[i]^b[i+4]^b[i+5]^b[i+6]^b[i+7].
    function automatic logic [7:0] affine_lin(input logic [7:0] b);
        return b ^ {b[3:0], b[7:4]} ^ {b[4:0], b[7:5]}
                 ^ {b[5:0], b[7:6]} ^ {b[6:0], b[7]};
    endfunction

    // Row r, column c of (affine o tower-to-polynomial); row masks are packed by row.
    function automatic lmat_t build_lmat();
        logic [63:0] flat;
        logic [63:0] basis_flat;
        logic [7:0]  col;
        logic [7:0]  bit_r;
        flat       = '0;
        basis_flat = TOWER_BASIS;
        for (int c = 0; c < 8; c++) begin
            col = affine_lin(8'(basis_flat >> (8 * c)));
            for (int r = 0; r < 8; r++) begin
                bit_r = col >> r;
                flat  = flat | (64'(bit_r[0]) << (8 * r + c));
            end
        end
        return lmat_t'(flat);
    endfunction

    localparam lmat_t L_MAT = build_lmat();

endpackage

// File: rtl/gf8_linmap.sv
// Combinational GF(2) 8x8 matrix-vector product; MAT holds one row mask per output bit.
module gf8_linmap
    import aes_ti_pkg::*;
#(
    parameter lmat_t MAT = '0
) (
    input  logic [7:0] x,
    output logic [7:0] y
);

    for (genvar r = 0; r < 8; r++) begin : g_row
        assign y[r] = ^(MAT[r] & x);
    end

endmodule

// File: rtl/sbox_share_compress.sv
// Re-masks and compresses the four inversion output shares to two, applies the
// output linear map plus 0x63, and carries the byte tags through the pipeline.
module sbox_share_compress
    import aes_ti_pkg::*;
#(
    parameter int INV_LAT = INV_LAT_DEF,
    parameter int NBYTES  = NBYTES_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       in_valid,
    input  logic       in_last,
    input  logic [7:0] sh0,
    input  logic [7:0] sh1,
    input  logic [7:0] sh2,
    input  logic [7:0] sh3,
    input  logic [7:0] r_comp,
    output logic [7:0] out0,
    output logic [7:0] out1,
    output logic       out_valid,
    output logic       out_last,
    output logic [3:0] out_idx
);

    localparam logic [3:0] IDX_LAST = 4'(NBYTES - 1);

    logic [INV_LAT-1:0] vld_dly;
    logic [INV_LAT-1:0] last_dly;
    logic [7:0]         q0_p1, q1_p1, q2_p1, q3_p1;
    logic               vld_p1, last_p1;
    logic [7:0]         lin0, lin1;

    // Tag delay line matching the upstream inversion latency; last is qualified by valid.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld_dly  <= '0;
            last_dly <= '0;
        end else begin
            vld_dly  <= (vld_dly << 1) | INV_LAT'(in_valid);
            last_dly <= (last_dly << 1) | INV_LAT'(in_valid & in_last);
        end
    end

    // Stage C: each share registered on its own before any cross-share XOR.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q0_p1   <= '0;
            q1_p1   <= '0;
            q2_p1   <= '0;
            q3_p1   <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            q0_p1   <= sh0 ^ r_comp;
            q1_p1   <= sh1;
            q2_p1   <= sh2 ^ r_comp;
            q3_p1   <= sh3;
            vld_p1  <= vld_dly[INV_LAT-1];
            last_p1 <= last_dly[INV_LAT-1];
        end
    end

    gf8_linmap #(.MAT(L_MAT)) u_lin0 (.x(q0_p1 ^ q1_p1), .y(lin0));
    gf8_linmap #(.MAT(L_MAT)) u_lin1 (.x(q2_p1 ^ q3_p1), .y(lin1));

    // Stage O: compressed shares through the output map; constant folded into share 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out0      <= '0;
            out1      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out0      <= lin0 ^ SBOX_CONST;
            out1      <= lin1;
            out_valid <= vld_p1;
            out_last  <= vld_p1 & last_p1;
        end
    end

    // Output byte index: advances per valid byte, wraps, and resyncs to 0 after a last byte.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_idx <= '0;
        end else if (out_valid) begin
            if (out_last || (out_idx == IDX_LAST)) begin
                out_idx <= '0;
            end else begin
                out_idx <= out_idx + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_sbox_share_compress.sv
// Directed bench for sbox_share_compress: shares are built from an independent
// GF(2^8) inverse and tower-basis table, results compared with a reference S-box.
module tb_sbox_share_compress;

    logic       CLK;
    logic       RST;
    logic       in_valid, in_last;
    logic [7:0] sh0, sh1, sh2, sh3, r_comp;
    logic [7:0] out0, out1;
    logic       out_valid, out_last;
    logic [3:0] out_idx;

    sbox_share_compress dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_last(in_last),
        .sh0(sh0), .sh1(sh1), .sh2(sh2), .sh3(sh3), .r_comp(r_comp),
        .out0(out0), .out1(out1), .out_valid(out_valid), .out_last(out_last),
        .out_idx(out_idx)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Tower basis elements 1, w, z, wz, y, wy, zy, wzy in the AES polynomial basis.
    logic [7:0] basis [8] = '{8'h01, 8'hBD, 8'hE0, 8'hED, 8'h42, 8'hF5, 8'hE5, 8'h92};
    logic [7:0] inv_tab [256];
    logic [7:0] sbox_tab [256];
    logic [7:0] tfwd [256];

    bit         s_vld [300];
    bit         s_last [300];
    logic [7:0] s_x [300];
    logic [3:0] exp_idx;
    int         nvalid, nlast;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1B;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] aff_std(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]};
    endfunction

    task automatic build_tables();
        logic [7:0] t;
        for (int a = 0; a < 256; a++) begin
            inv_tab[a] = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv_tab[a] = 8'(b);
        end
        for (int a = 0; a < 256; a++) sbox_tab[a] = aff_std(inv_tab[a]) ^ 8'h63;
        for (int v = 0; v < 256; v++) begin
            t = 8'h00;
            for (int i = 0; i < 8; i++)
                if (((v >> i) & 1) != 0) t = t ^ basis[i];
            tfwd[t] = 8'(v);
        end
    endtask

    task automatic clear_stim();
        for (int i = 0; i < 300; i++) begin
            s_vld[i] = 1'b0; s_last[i] = 1'b0; s_x[i] = 8'h00;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        in_valid = 1'b0;
        step();
        RST = 1'b0;
        exp_idx = 4'd0;
        step();
    endtask

    // Plays s_* for n cycles, presenting shares INV_LAT=2 cycles after each in_valid,
    // and checks every output cycle against the reference.
    task automatic run_seq(input int n, input bit zero_sh, input bit rfix,
                           input logic [7:0] rval, input bit chk_o1, input logic [7:0] exp_o1);
        bit         ev;
        int         j;
        logic [7:0] y;
        nvalid = 0;
        nlast  = 0;
        for (int k = 0; k < n + 5; k++) begin
            ev = 1'b0;
            if (k >= 4) ev = s_vld[k-4];
            chk("vld", 8'(out_valid), 8'(ev));
            if (ev) begin
                chk("sbox", out0 ^ out1, sbox_tab[s_x[k-4]]);
                chk("last", 8'(out_last), 8'(s_last[k-4]));
                chk("idx", 8'(out_idx), 8'(exp_idx));
                if (chk_o1) chk("out1", out1, exp_o1);
                if (s_x[k-4] == 8'h53) chk("s53", out0 ^ out1, 8'hED);
                if (s_last[k-4]) exp_idx = 4'd0;
                else if (exp_idx == 4'd15) exp_idx = 4'd0;
                else exp_idx = exp_idx + 4'd1;
                nvalid++;
                if (out_last) nlast++;
            end else begin
                chk("lastlow", 8'(out_last), 8'h00);
            end
            in_valid = (k < n) ? s_vld[k] : 1'b0;
            in_last  = (k < n && s_vld[k]) ? s_last[k] : 1'($urandom);
            j = k - 2;
            if (j >= 0 && j < n && s_vld[j]) begin
                if (zero_sh) begin
                    sh0 = 8'h00; sh1 = 8'h00; sh2 = 8'h00; sh3 = 8'h00;
                end else begin
                    y   = tfwd[inv_tab[s_x[j]]];
                    sh0 = 8'($urandom); sh1 = 8'($urandom); sh2 = 8'($urandom);
                    sh3 = y ^ sh0 ^ sh1 ^ sh2;
                end
            end else begin
                sh0 = 8'($urandom); sh1 = 8'($urandom);
                sh2 = 8'($urandom); sh3 = 8'($urandom);
            end
            r_comp = rfix ? rval : 8'($urandom);
            step();
        end
    endtask

    initial begin
        RST = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        sh0 = 8'h00; sh1 = 8'h00; sh2 = 8'h00; sh3 = 8'h00; r_comp = 8'h00;
        exp_idx = 4'd0;
        build_tables();
        #12;
        chk("rst_vld", 8'(out_valid), 8'h00);
        chk("rst_last", 8'(out_last), 8'h00);
        chk("rst_idx", 8'(out_idx), 8'h00);
        chk("rst_out0", out0, 8'h00);
        chk("rst_out1", out1, 8'h00);
        step();
        RST = 1'b0;
        step();

        // Zero shares, r_comp=0, then r_comp=0xA5 (out1 = L(0xA5) = 0xCD).
        clear_stim();
        s_vld[0] = 1'b1;
        run_seq(1, 1'b1, 1'b1, 8'h00, 1'b1, 8'h00);
        run_seq(1, 1'b1, 1'b1, 8'hA5, 1'b1, 8'hCD);

        // All 256 inputs back to back.
        do_reset();
        clear_stim();
        for (int i = 0; i < 256; i++) begin s_vld[i] = 1'b1; s_x[i] = 8'(i); end
        run_seq(256, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

        // 20-byte stream: index wraps 15 -> 0.
        do_reset();
        clear_stim();
        for (int i = 0; i < 20; i++) begin s_vld[i] = 1'b1; s_x[i] = 8'($urandom); end
        run_seq(20, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("stream_cnt", 8'(nvalid), 8'd20);

        // Last on byte 4, 3-cycle gap, 2 more bytes restart at index 0.
        do_reset();
        clear_stim();
        for (int i = 0; i < 10; i++) begin
            s_vld[i] = (i < 5 || i > 7);
            s_x[i]   = 8'(8'h10 + i);
        end
        s_last[4] = 1'b1;
        run_seq(10, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("last_cnt", 8'(nlast), 8'd1);
        chk("resync_cnt", 8'(nvalid), 8'd7);

        // Gap pattern 1,0,1,1,0,1.
        do_reset();
        clear_stim();
        s_vld[0] = 1'b1; s_vld[2] = 1'b1; s_vld[3] = 1'b1; s_vld[5] = 1'b1;
        for (int i = 0; i < 6; i++) s_x[i] = 8'($urandom);
        run_seq(6, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        chk("gap_cnt", 8'(nvalid), 8'd4);

        // Asynchronous reset with bytes in flight.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_last = 1'b0;
            sh0 = 8'($urandom); sh1 = 8'($urandom); sh2 = 8'($urandom); sh3 = 8'($urandom);
            r_comp = 8'($urandom);
            step();
        end
        in_valid = 1'b0;
        chk("pre_rst_vld", 8'(out_valid), 8'h01);
        chk("pre_rst_idx", 8'(out_idx), 8'h01);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_vld", 8'(out_valid), 8'h00);
        chk("arst_idx", 8'(out_idx), 8'h00);
        chk("arst_last", 8'(out_last), 8'h00);
        chk("arst_out0", out0, 8'h00);
        chk("arst_out1", out1, 8'h00);
        step();
        RST = 1'b0;
        exp_idx = 4'd0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("post_rst_vld", 8'(out_valid), 8'h00);
        end
        clear_stim();
        s_vld[0] = 1'b1; s_x[0] = 8'h53;
        run_seq(1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
